// File: rtl/ldb_fetch_if.sv
// Bundles the command, memory and response ports of the byte-load fetch controller.
// slave = controller side, master = the environment that issues commands and models memory.
interface ldb_fetch_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_signed;

    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [31:0]           mem_rdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_word;
    logic [1:0]            rsp_sel;
    logic                  rsp_signed;
    logic                  rsp_err;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_signed,
        output cmd_ready,
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output rsp_valid, rsp_word, rsp_sel, rsp_signed, rsp_err,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_signed,
        input  cmd_ready,
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  rsp_valid, rsp_word, rsp_sel, rsp_signed, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/ldb_fetch.sv
// Byte-load fetch controller: one word-aligned read per command, one command in flight.
// Define LDB_FETCH_TIMEOUT_EN to flag loads the memory never answers after TIMEOUT_CYCLES.
module ldb_fetch #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          srst_n,
    ldb_fetch_if.slave    bus
);

    if (ADDR_WIDTH < 3) begin : g_bad_addr_width
        $error("ldb_fetch: ADDR_WIDTH must be >= 3");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("ldb_fetch: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RSP
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           rsp_word_q;
    logic [1:0]            rsp_sel_q;
    logic                  rsp_signed_q;
    logic                  timeout_hit;

`ifdef LDB_FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             rsp_err_q;

    // Fires on the last of TIMEOUT_CYCLES silent WAIT cycles; a same-cycle rvalid wins.
    assign timeout_hit = (state == WAIT) && !bus.mem_rvalid &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            wait_cnt <= '0;
        end else if (state == REQ && bus.mem_gnt) begin
            wait_cnt <= '0;
        end else if (state == WAIT && !bus.mem_rvalid) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            rsp_err_q <= 1'b0;
        end else if (state == WAIT) begin
            if (bus.mem_rvalid) begin
                rsp_err_q <= 1'b0;
            end else if (timeout_hit) begin
                rsp_err_q <= 1'b1;
            end
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.cmd_valid)                   state_nxt = REQ;
            REQ:  if (bus.mem_gnt)                     state_nxt = WAIT;
            WAIT: if (bus.mem_rvalid || timeout_hit)   state_nxt = RSP;
            RSP:  if (bus.rsp_ready)                   state_nxt = IDLE;
            default:                                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            mem_addr_q   <= '0;
            rsp_word_q   <= '0;
            rsp_sel_q    <= '0;
            rsp_signed_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        mem_addr_q   <= {bus.cmd_addr[ADDR_WIDTH-1:2], 2'b00};
                        rsp_sel_q    <= bus.cmd_addr[1:0];
                        rsp_signed_q <= bus.cmd_signed;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        rsp_word_q <= bus.mem_rdata;
                    end else if (timeout_hit) begin
                        rsp_word_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Only cmd_ready sees an input (srst_n) combinationally; the rest is state or flops.
    assign bus.cmd_ready  = srst_n & (state == IDLE);
    assign bus.mem_req    = (state == REQ);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.rsp_valid  = (state == RSP);
    assign bus.rsp_word   = rsp_word_q;
    assign bus.rsp_sel    = rsp_sel_q;
    assign bus.rsp_signed = rsp_signed_q;

endmodule

// File: tb/tb_ldb_fetch.sv
// Scoreboard bench for ldb_fetch: directed and randomized loads against a simple load model.
// Timeout scenarios run only when LDB_FETCH_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 4).
module tb_ldb_fetch;

    localparam int AW = 32;
    localparam int TO = 4;

    typedef struct packed {
        logic [31:0] word;
        logic [1:0]  sel;
        logic        sgn;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic srst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    rsp_t exp_q[$];

    ldb_fetch_if #(.ADDR_WIDTH(AW)) bus ();

    ldb_fetch #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk    (clk),
        .srst_n (srst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // A byte load returns the whole aligned word; the lane and signedness travel alongside.
    function automatic rsp_t model(input logic [31:0] addr, input logic sgn,
                                   input logic [31:0] data, input bit timed_out);
        rsp_t r;
        r.word = timed_out ? 32'd0 : data;
        r.sel  = 2'(addr % 4);
        r.sgn  = sgn;
        r.err  = timed_out;
        return r;
    endfunction

    // Monitor: every response handshake must match the oldest expected response.
    always @(negedge clk) begin
        if (srst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("sb_rsp_word",   bus.rsp_word,   e.word);
                check("sb_rsp_sel",    bus.rsp_sel,    e.sel);
                check("sb_rsp_signed", bus.rsp_signed, e.sgn);
                check("sb_rsp_err",    bus.rsp_err,    e.err);
            end
        end
    end

    // rv_dly < 0 means the memory never answers (timeout builds only).
    task automatic do_load(input logic [31:0] addr, input logic sgn, input int gnt_dly,
                           input int rv_dly, input int rdy_dly, input logic [31:0] data,
                           input bit dual);
        rsp_t e;
        int   budget;
        logic [31:0] exp_addr;
        exp_addr = addr - (addr % 4);
        budget = 0;
        while (!bus.cmd_ready && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 20) check("cmd_ready_wait", 0, 1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_addr   = addr;
        bus.cmd_signed = sgn;
        @(posedge clk); #1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_addr   = $urandom;
        bus.cmd_signed = ~sgn;
        e = model(addr, sgn, data, rv_dly < 0);
        exp_q.push_back(e);

        for (int i = 0; i <= gnt_dly; i++) begin
            if (i == gnt_dly) begin
                bus.mem_gnt = 1'b1;
                if (dual) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = ~data;
                end
            end
            @(negedge clk);
            check("req_mem_req",   bus.mem_req,   1);
            check("req_mem_addr",  bus.mem_addr,  exp_addr);
            check("req_cmd_ready", bus.cmd_ready, 0);
            @(posedge clk); #1;
        end
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;

        for (int i = 0; i <= ((rv_dly < 0) ? TO - 1 : rv_dly); i++) begin
            if (i == rv_dly) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = data;
            end
            @(negedge clk);
            check("wait_mem_req",   bus.mem_req,   0);
            check("wait_rsp_valid", bus.rsp_valid, 0);
            check("wait_cmd_ready", bus.cmd_ready, 0);
            @(posedge clk); #1;
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;

        for (int i = 0; i <= rdy_dly; i++) begin
            if (i == rdy_dly) bus.rsp_ready = 1'b1;
            @(negedge clk);
            check("rsp_valid",      bus.rsp_valid,  1);
            check("rsp_word",       bus.rsp_word,   e.word);
            check("rsp_sel",        bus.rsp_sel,    e.sel);
            check("rsp_signed",     bus.rsp_signed, e.sgn);
            check("rsp_err",        bus.rsp_err,    e.err);
            check("rsp_mem_addr",   bus.mem_addr,   exp_addr);
            check("rsp_cmd_ready",  bus.cmd_ready,  0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("post_cmd_ready", bus.cmd_ready, 1);
        check("post_rsp_valid", bus.rsp_valid, 0);
    endtask

    initial begin
        srst_n         = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_signed = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready",  bus.cmd_ready,  0);
        check("rst_mem_req",    bus.mem_req,    0);
        check("rst_mem_addr",   bus.mem_addr,   0);
        check("rst_rsp_valid",  bus.rsp_valid,  0);
        check("rst_rsp_word",   bus.rsp_word,   0);
        check("rst_rsp_sel",    bus.rsp_sel,    0);
        check("rst_rsp_signed", bus.rsp_signed, 0);
        check("rst_rsp_err",    bus.rsp_err,    0);
        srst_n = 1'b1;
        #1;
        check("rel_cmd_ready", bus.cmd_ready, 1);

        // Zero-wait byte load: response in cycle 3.
        do_load(32'h0000_1003, 1'b1, 0, 0, 0, 32'h788E_FD0C, 1'b0);
        // Wait states and back-pressure.
        do_load(32'h0000_2002, 1'b0, 3, 4, 5, 32'hCAFE_F00D, 1'b0);
        // All four byte lanes.
        for (int l = 0; l < 4; l++)
            do_load(32'h8000_0010 + 32'(l), 1'(l), 1, 0, 0, 32'h1111_0000 + 32'(l), 1'b0);
        // gnt with a same-cycle rvalid in REQ: only the later rvalid is captured.
        do_load(32'h0000_4001, 1'b1, 1, 2, 0, 32'h5A5A_A5A5, 1'b1);
        do_load(32'h0000_4002, 1'b0, 0, 0, 1, 32'h0F0F_F0F0, 1'b1);

        // Reset while in WAIT: the later rvalid must be ignored.
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h0000_3001;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.mem_gnt   = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt   = 1'b0;
        @(negedge clk);
        check("rwait_mem_req", bus.mem_req, 0);
        srst_n = 1'b0;
        #1;
        check("rst_low_cmd_ready", bus.cmd_ready, 0);
        @(posedge clk); #1;
        srst_n         = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rrel_cmd_ready", bus.cmd_ready, 1);
        check("rrel_rsp_valid", bus.rsp_valid, 0);
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        check("rrel2_rsp_valid", bus.rsp_valid, 0);
        check("rrel2_mem_req",   bus.mem_req,   0);
        check("rrel2_rsp_word",  bus.rsp_word,  0);
        check("rrel2_cmd_ready", bus.cmd_ready, 1);

`ifdef LDB_FETCH_TIMEOUT_EN
        // No rvalid: error response after TO WAIT cycles, then rvalid on the expiry cycle.
        do_load(32'h0000_5003, 1'b1, 0, -1, 2, 32'h1234_5678, 1'b0);
        do_load(32'h0000_5001, 1'b0, 1, TO - 1, 0, 32'h8765_4321, 1'b0);
`endif

        for (int n = 0; n < 30; n++)
            do_load($urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                    ($urandom_range(0, 3) == 0));

        repeat (2) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
